// File: rtl/vcr_ugal_sniffer.sv
// rtl/vcr_ugal_sniffer.sv - per-port downstream buffer occupancy sniffer for UGAL routing
//
// Tracks, for every network output port and every VC, how many flits are sitting
// in the downstream input buffer (flits sent minus credits returned). The summed
// occupancy of each port is exported as a registered value for adaptive routing
// decisions. A sticky per-port flag records any accounting inconsistency.
//
// Ports:
//   clk             - clock
//   reset           - active-low reset (asynchronous by default, see reset_type)
//   flit_valid_out  - [num_net_ports] flit sent on port p this cycle
//   flit_vc_out     - [num_net_ports*vc_idx_width] VC of that flit, port p at slice p
//   credit_valid_in - [num_net_ports] credit returned on port p this cycle
//   credit_vc_in    - [num_net_ports*vc_idx_width] VC of that credit, port p at slice p
//   credit_count    - [num_net_ports*credit_count_width] registered port occupancy,
//                     port 0 in the most significant (leftmost) slice
//   error           - [num_net_ports] sticky overflow/underflow flag per port

`timescale 1ns/1ps

`ifndef CONNECTIVITY_LINE
`define CONNECTIVITY_LINE 0
`endif
`ifndef CONNECTIVITY_RING
`define CONNECTIVITY_RING 1
`endif
`ifndef CONNECTIVITY_FULL
`define CONNECTIVITY_FULL 2
`endif
`ifndef RESET_TYPE_ASYNC
`define RESET_TYPE_ASYNC 0
`endif
`ifndef RESET_TYPE_SYNC
`define RESET_TYPE_SYNC 1
`endif

module vcr_ugal_sniffer #(
    parameter int num_flit_buffers     = 8,
    parameter int num_message_classes  = 1,
    parameter int num_resource_classes = 2,
    parameter int num_vcs_per_class    = 1,
    parameter int num_routers_per_dim  = 4,
    parameter int num_dimensions       = 2,
    parameter int num_nodes_per_router = 4,
    parameter int connectivity         = `CONNECTIVITY_FULL,
    parameter int reset_type           = `RESET_TYPE_ASYNC,
    localparam int num_vcs = num_message_classes * num_resource_classes * num_vcs_per_class,
    localparam int vc_idx_width = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int num_neighbors_per_dim =
        (connectivity == `CONNECTIVITY_FULL) ? (num_routers_per_dim - 1) : 2,
    localparam int num_net_ports = num_dimensions * num_neighbors_per_dim,
    localparam int credit_count_width = $clog2(num_vcs * num_flit_buffers) + 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [num_net_ports-1:0]                    flit_valid_out,
    input  logic [num_net_ports*vc_idx_width-1:0]       flit_vc_out,
    input  logic [num_net_ports-1:0]                    credit_valid_in,
    input  logic [num_net_ports*vc_idx_width-1:0]       credit_vc_in,
    output logic [num_net_ports*credit_count_width-1:0] credit_count,
    output logic [num_net_ports-1:0]                    error
);

    // Each counter must hold 0..num_flit_buffers inclusive.
    localparam int occ_width = $clog2(num_flit_buffers + 1);
    localparam int occ_bits  = num_net_ports * num_vcs * occ_width;
    localparam logic [occ_width-1:0] occ_max = occ_width'(num_flit_buffers);

    // Counters are kept flattened: entry (p, v) lives at (p*num_vcs + v)*occ_width.
    logic [occ_bits-1:0]                          r_occ;
    logic [occ_bits-1:0]                          w_occ_next;
    logic [num_net_ports-1:0]                     r_error;
    logic [num_net_ports-1:0]                     w_error_next;
    logic [num_net_ports*credit_count_width-1:0]  r_credit_count;
    logic [num_net_ports*credit_count_width-1:0]  w_credit_count_next;
    logic [credit_count_width-1:0]                w_sum [num_net_ports];

    always_comb begin
        logic                 w_inc;
        logic                 w_dec;
        logic [occ_width-1:0] w_cur;
        w_occ_next          = r_occ;
        w_error_next        = r_error;
        w_credit_count_next = '0;
        w_inc               = 1'b0;
        w_dec               = 1'b0;
        w_cur               = '0;
        for (int p = 0; p < num_net_ports; p++) begin
            w_sum[p] = '0;
            for (int v = 0; v < num_vcs; v++) begin
                w_cur = r_occ[(p*num_vcs + v)*occ_width +: occ_width];
                w_inc = flit_valid_out[p] &&
                        (flit_vc_out[p*vc_idx_width +: vc_idx_width] == vc_idx_width'(v));
                w_dec = credit_valid_in[p] &&
                        (credit_vc_in[p*vc_idx_width +: vc_idx_width] == vc_idx_width'(v));
                // A flit and a credit on the same VC cancel out, even at the limits.
                case ({w_inc, w_dec})
                    2'b10: begin
                        if (w_cur == occ_max)
                            w_error_next[p] = 1'b1;
                        else
                            w_occ_next[(p*num_vcs + v)*occ_width +: occ_width] = w_cur + 1'b1;
                    end
                    2'b01: begin
                        if (w_cur == '0)
                            w_error_next[p] = 1'b1;
                        else
                            w_occ_next[(p*num_vcs + v)*occ_width +: occ_width] = w_cur - 1'b1;
                    end
                    default: ;
                endcase
                // Sum the current (registered) counters; the extra output register
                // gives the two-cycle event-to-output latency.
                w_sum[p] = w_sum[p] + credit_count_width'(w_cur);
            end
            w_credit_count_next[(num_net_ports-1-p)*credit_count_width +: credit_count_width] =
                w_sum[p];
        end
    end

    generate
        if (reset_type == `RESET_TYPE_ASYNC) begin : g_async_reset
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_occ          <= '0;
                    r_error        <= '0;
                    r_credit_count <= '0;
                end else begin
                    r_occ          <= w_occ_next;
                    r_error        <= w_error_next;
                    r_credit_count <= w_credit_count_next;
                end
            end
        end else begin : g_sync_reset
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_occ          <= '0;
                    r_error        <= '0;
                    r_credit_count <= '0;
                end else begin
                    r_occ          <= w_occ_next;
                    r_error        <= w_error_next;
                    r_credit_count <= w_credit_count_next;
                end
            end
        end
    endgenerate

    assign credit_count = r_credit_count;
    assign error        = r_error;

endmodule

// File: tb/tb_vcr_ugal_sniffer.sv
// tb/tb_vcr_ugal_sniffer.sv - directed self-checking bench for vcr_ugal_sniffer

`timescale 1ns/1ps

module tb_vcr_ugal_sniffer;

    logic        clk;
    logic        reset;
    logic [5:0]  fv;
    logic [5:0]  fvc;
    logic [5:0]  cv;
    logic [5:0]  cvc;
    logic [29:0] cc;
    logic [5:0]  err;

    int checks;
    int errors;

    vcr_ugal_sniffer dut (
        .clk             (clk),
        .reset           (reset),
        .flit_valid_out  (fv),
        .flit_vc_out     (fvc),
        .credit_valid_in (cv),
        .credit_vc_in    (cvc),
        .credit_count    (cc),
        .error           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port p slice of credit_count sits at bit (5-p)*5 (port 0 leftmost).
    function automatic logic [29:0] at_port(input int p, input int val);
        logic [29:0] w;
        w = 30'(val);
        return w << ((5 - p) * 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fv  = '0;
        fvc = '0;
        cv  = '0;
        cvc = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        reset = 1'b0;
        #3;
        check("reset_cc", 32'(cc), 32'(0));
        check("reset_err", 32'(err), 32'(0));
        tick();
        tick();
        reset = 1'b1;

        // Three flits on port 2 VC0
        fv = 6'b000100;
        tick();
        check("s1_lat0", 32'(cc), 32'(0));
        tick();
        check("s1_cnt1", 32'(cc), 32'(at_port(2, 1)));
        tick();
        clear_inputs();
        check("s1_cnt2", 32'(cc), 32'(at_port(2, 2)));
        tick();
        check("s1_cnt3", 32'(cc), 32'(at_port(2, 3)));
        tick();
        check("s1_hold3", 32'(cc), 32'(at_port(2, 3)));

        // Overflow on port 0 VC1
        do_reset();
        fv  = 6'b000001;
        fvc = 6'b000001;
        repeat (8) tick();
        check("s2_err_pre", 32'(err), 32'(0));
        tick();
        check("s2_err_ovf", 32'(err), 32'(6'b000001));
        clear_inputs();
        tick();
        check("s2_cc8", 32'(cc), 32'(at_port(0, 8)));
        tick();
        tick();
        check("s2_cc8_hold", 32'(cc), 32'(at_port(0, 8)));
        check("s2_err_sticky", 32'(err), 32'(6'b000001));

        // Port 4 simultaneous events
        do_reset();
        fv = 6'b010000;
        repeat (5) tick();
        cv = 6'b010000;
        tick();
        fvc = 6'b010000;
        tick();
        check("s3_cc5_a", 32'(cc), 32'(at_port(4, 5)));
        clear_inputs();
        tick();
        tick();
        check("s3_cc5_b", 32'(cc), 32'(at_port(4, 5)));
        check("s3_err0", 32'(err), 32'(0));
        cv  = 6'b010000;
        cvc = 6'b010000;
        tick();
        clear_inputs();
        tick();
        tick();
        check("s3_vc1_credit", 32'(cc), 32'(at_port(4, 4)));
        check("s3_err_still0", 32'(err), 32'(0));
        cv  = 6'b010000;
        cvc = 6'b010000;
        tick();
        clear_inputs();
        tick();
        tick();
        check("s3_vc1_underflow", 32'(err), 32'(6'b010000));
        check("s3_cc_after_uf", 32'(cc), 32'(at_port(4, 4)));

        // Port 5 filled to 16, then drained
        do_reset();
        fv = 6'b100000;
        repeat (8) tick();
        fvc = 6'b100000;
        repeat (8) tick();
        clear_inputs();
        tick();
        tick();
        check("s4_cc16", 32'(cc), 32'(at_port(5, 16)));
        check("s4_err_full", 32'(err), 32'(0));
        cv = 6'b100000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("s4_drain_step", 32'(cc), 32'(at_port(5, 17 - k)));
        end
        cvc = 6'b100000;
        repeat (8) tick();
        clear_inputs();
        tick();
        tick();
        check("s4_cc0", 32'(cc), 32'(0));
        check("s4_err_empty", 32'(err), 32'(0));

        // Credit on empty port 3
        do_reset();
        cv = 6'b001000;
        tick();
        clear_inputs();
        check("s5_err3", 32'(err), 32'(6'b001000));
        tick();
        tick();
        check("s5_cc0", 32'(cc), 32'(0));

        // Mid-traffic reset with port 1 at 6
        do_reset();
        fv = 6'b000010;
        repeat (6) tick();
        clear_inputs();
        tick();
        tick();
        check("s6_cc6", 32'(cc), 32'(at_port(1, 6)));
        cv = 6'b001000;
        tick();
        clear_inputs();
        check("s6_err_set", 32'(err), 32'(6'b001000));
        fv = 6'b000010;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("s6_async_cc", 32'(cc), 32'(0));
        check("s6_async_err", 32'(err), 32'(0));
        tick();
        tick();
        check("s6_ignored_cc", 32'(cc), 32'(0));
        reset = 1'b1;
        tick();
        fv = '0;
        check("s6_first_lat", 32'(cc), 32'(0));
        tick();
        check("s6_first_cnt", 32'(cc), 32'(at_port(1, 1)));
        check("s6_err_clear", 32'(err), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vcr_ugal_sniffer.md
VCR_UGAL_SNIFFER -- requirements
Module: vcr_ugal_sniffer

Interface
REQ-001 Parameters, given as name, default, meaning:
- num_flit_buffers, 8, flit buffer entries per VC at the downstream input.
- num_message_classes, 1, message classes.
- num_resource_classes, 2, resource classes.
- num_vcs_per_class, 1, VCs per packet class.
- num_routers_per_dim, 4, routers per dimension.
- num_dimensions, 2, network dimensions.
- num_nodes_per_router, 4, concentration factor.
- connectivity, `CONNECTIVITY_FULL, connectivity within each dimension.
- reset_type, `RESET_TYPE_ASYNC, reset style of the internal flops.
REQ-002 Derived values:
- num_vcs = num_message_classes*num_resource_classes*num_vcs_per_class.
- vc_idx_width = clogb(num_vcs).
- num_net_ports = num_dimensions*num_neighbors_per_dim, where num_neighbors_per_dim is 2 for LINE/RING and num_routers_per_dim-1 for FULL.
- credit_count_width = clogb(num_vcs*num_flit_buffers)+1.
REQ-003 Ports, given as name, direction, width, meaning:
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous, active-low.
- flit_valid_out, in, num_net_ports, a flit is sent on network output port p this cycle.
- flit_vc_out, in, num_net_ports*vc_idx_width, VC of that flit; port p occupies slice p.
- credit_valid_in, in, num_net_ports, a credit is returned from downstream on port p.
- credit_vc_in, in, num_net_ports*vc_idx_width, VC of that credit.
- credit_count, out, num_net_ports*credit_count_width, downstream occupancy per port; port 0 is the leftmost slice.
- error, out, num_net_ports, sticky per-port accounting error flag.

Function
REQ-004 For every network port p and every VC v, the block SHALL keep an occupancy counter occ[p][v] with range 0..num_flit_buffers.
REQ-005 occ[p][v] SHALL increment on a sampled edge when flit_valid_out[p] is high and flit_vc_out[p]==v.
REQ-006 occ[p][v] SHALL decrement on a sampled edge when credit_valid_in[p] is high and credit_vc_in[p]==v.
REQ-007 If an increment and a decrement hit the same occ[p][v] on the same edge, the counter SHALL hold and no error SHALL be raised.
REQ-008 An increment and a decrement that hit different VCs of the same port on the same edge SHALL both be applied independently.
REQ-009 An increment alone at occ==num_flit_buffers SHALL leave the counter unchanged and set error[p] (overflow).
REQ-010 A decrement alone at occ==0 SHALL leave the counter unchanged and set error[p] (underflow).
REQ-011 Once set, error[p] SHALL remain set until reset.
REQ-012 The port sum S[p] SHALL be the sum over v of occ[p][v], computed in credit_count_width bits with no truncation; its maximum is num_vcs*num_flit_buffers.
REQ-013 The credit_count slice for port p SHALL be a registered copy of S[p], updated on every edge.
REQ-014 An event sampled at edge N SHALL be visible on credit_count after edge N+1, a latency of 2 cycles.
REQ-015 credit_count SHALL never skip an intermediate value when exactly one event per cycle occurs on a port.
REQ-016 Ports SHALL be fully independent; events on port p SHALL never alter the counters, output slice, or error flag of any other port.
REQ-017 The valid inputs SHALL be sampled only on rising clk edges; the VC inputs are don't-care while their valid input is low.

Reset
REQ-018 While reset is low, all occ[p][v], all credit_count slices, and all error bits SHALL be 0, asynchronously to clk.
REQ-019 Assertion of reset in the middle of operation SHALL clear all state immediately; events presented during reset SHALL be ignored.
REQ-020 The first event SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-021 The bench SHALL use defaults (num_vcs=2, num_net_ports=6, credit_count_width=5) and cover these scenarios:
- Reset, then 3 flits on port 2 VC0 on consecutive cycles -> port 2 slice reads 1, 2, 3 starting two cycles after the first flit; all other slices read 0.
- 8 flits on port 0 VC1, then a 9th flit with no credit -> slice reads 8; error[0]=1 and stays 1; other error bits 0.
- Port 4 at VC0 occupancy 5: a flit and a credit on VC0 in the same cycle -> slice stays 5; then a flit on VC1 and a credit on VC0 in the same cycle -> slice stays 5, with VC1=1 and VC0=4.
- Both VCs of port 5 filled to 8 each -> slice reads 16 with no wrap in 5 bits; 16 credits returned -> slice reads 0 and no error.
- Credit on port 3 with occupancy 0 -> slice stays 0; error[3]=1.
- Reset pulsed low mid-traffic with port 1 at 6 -> slice and error clear immediately; the first flit after release makes the slice read 1 two cycles later.
